// File: rtl/td4_pkg.sv
// Shared opcode encodings for the TD4-class core (bit-reversed TD4 encoding).
package td4_pkg;

    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_BA  = 4'b0010;
    localparam logic [3:0] OP_IN_A    = 4'b0100;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_JNC     = 4'b0111;
    localparam logic [3:0] OP_MOV_AB  = 4'b1000;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_ADD_B   = 4'b1010;
    localparam logic [3:0] OP_MOV_AIM = 4'b1100;
    localparam logic [3:0] OP_OUT_IM  = 4'b1101;
    localparam logic [3:0] OP_MOV_BIM = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

endpackage

// File: rtl/td4_alu.sv
// Combinational DW-bit adder with carry-out for the TD4 core.
module td4_alu #(
    parameter int unsigned DW = 4
) (
    input  logic [DW-1:0] i_operand,
    input  logic [DW-1:0] i_imm,
    output logic [DW-1:0] o_sum,
    output logic          o_cout
);

    logic [DW:0] w_sum;

    assign w_sum  = {1'b0, i_operand} + {1'b0, i_imm};
    assign o_sum  = w_sum[DW-1:0];
    assign o_cout = w_sum[DW];

endmodule

// File: rtl/td4_core_param.sv
// Parametrised TD4-class accumulator core: one instruction per enabled clock,
// instruction fetched combinationally from external ROM at pc_out.
module td4_core_param
    import td4_pkg::*;
#(
    parameter int unsigned DW = 4,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] immediate,
    input  logic [DW-1:0] in_port,
    output logic [AW-1:0] pc_out,
    output logic [DW-1:0] reg_a,
    output logic [DW-1:0] reg_b,
    output logic [DW-1:0] out_port,
    output logic          carry
);

    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [DW-1:0] r_out;
    logic          r_carry;

    logic [AW-1:0] w_pc_d;
    logic [DW-1:0] w_a_d;
    logic [DW-1:0] w_b_d;
    logic [DW-1:0] w_out_d;
    logic          w_carry_d;

    logic [DW-1:0] w_alu_op;
    logic [DW-1:0] w_alu_sum;
    logic          w_alu_cout;
    logic [AW-1:0] w_jmp_tgt;

    assign w_alu_op = (opcode == OP_ADD_B) ? r_b : r_a;

    td4_alu #(
        .DW (DW)
    ) u_alu (
        .i_operand (w_alu_op),
        .i_imm     (immediate),
        .o_sum     (w_alu_sum),
        .o_cout    (w_alu_cout)
    );

    // Size cast zero-extends when DW<AW and keeps the low AW bits otherwise.
    assign w_jmp_tgt = AW'(immediate);

    always_comb begin
        w_pc_d    = r_pc + AW'(1);
        w_a_d     = r_a;
        w_b_d     = r_b;
        w_out_d   = r_out;
        w_carry_d = 1'b0;
        case (opcode)
            OP_ADD_A: begin
                w_a_d     = w_alu_sum;
                w_carry_d = w_alu_cout;
            end
            OP_ADD_B: begin
                w_b_d     = w_alu_sum;
                w_carry_d = w_alu_cout;
            end
            OP_MOV_AB:  w_a_d   = r_b;
            OP_MOV_BA:  w_b_d   = r_a;
            OP_MOV_AIM: w_a_d   = immediate;
            OP_MOV_BIM: w_b_d   = immediate;
            OP_IN_A:    w_a_d   = in_port;
            OP_IN_B:    w_b_d   = in_port;
            OP_OUT_B:   w_out_d = r_b;
            OP_OUT_IM:  w_out_d = immediate;
            OP_JMP:     w_pc_d  = w_jmp_tgt;
            OP_JNC: begin
                if (!r_carry) begin
                    w_pc_d = w_jmp_tgt;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
        end else if (en) begin
            r_pc    <= w_pc_d;
            r_a     <= w_a_d;
            r_b     <= w_b_d;
            r_out   <= w_out_d;
            r_carry <= w_carry_d;
        end
    end

    assign pc_out   = r_pc;
    assign reg_a    = r_a;
    assign reg_b    = r_b;
    assign out_port = r_out;
    assign carry    = r_carry;

endmodule

// File: tb/tb_td4_core_param.sv
// Scoreboard bench for td4_core_param: random and directed programs against a mnemonic-level model.
module tb_td4_core_param;

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] o;
        logic       c;
    } state_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic [3:0] in_port;
    logic [3:0] pc_out;
    logic [3:0] reg_a;
    logic [3:0] reg_b;
    logic [3:0] out_port;
    logic       carry;

    logic       en8;
    logic [3:0] opcode8;
    logic [7:0] imm8;
    logic [7:0] in8;
    logic [5:0] pc8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] out8;
    logic       carry8;

    int checks;
    int failures;

    state_t exp_q[$];
    int m_pc, m_a, m_b, m_o, m_c;

    td4_core_param #(.DW(4), .AW(4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .opcode    (opcode),
        .immediate (immediate),
        .in_port   (in_port),
        .pc_out    (pc_out),
        .reg_a     (reg_a),
        .reg_b     (reg_b),
        .out_port  (out_port),
        .carry     (carry)
    );

    td4_core_param #(.DW(8), .AW(6)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en8),
        .opcode    (opcode8),
        .immediate (imm8),
        .in_port   (in8),
        .pc_out    (pc8),
        .reg_a     (a8),
        .reg_b     (b8),
        .out_port  (out8),
        .carry     (carry8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every executed (or held) edge has one expected state queued.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            state_t e;
            state_t act;
            e   = exp_q.pop_front();
            act = '{pc: pc_out, a: reg_a, b: reg_b, o: out_port, c: carry};
            checks++;
            if (act !== e) begin
                failures++;
                $display("FAIL scoreboard t=%0t actual pc=%h a=%h b=%h out=%h c=%b required pc=%h a=%h b=%h out=%h c=%b",
                         $time, act.pc, act.a, act.b, act.o, act.c, e.pc, e.a, e.b, e.o, e.c);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_a = 0; m_b = 0; m_o = 0; m_c = 0;
    endtask

    // Model works from the mnemonic table with integer arithmetic.
    task automatic model_exec(input int op, input int im, input int inp);
        int sum;
        int nc;
        int npc;
        nc  = 0;
        npc = (m_pc + 1) % 16;
        case (op)
            'b0000: begin sum = m_a + im; m_a = sum % 16; nc = sum / 16; end
            'b1010: begin sum = m_b + im; m_b = sum % 16; nc = sum / 16; end
            'b1000: m_a = m_b;
            'b0010: m_b = m_a;
            'b1100: m_a = im;
            'b1110: m_b = im;
            'b0100: m_a = inp;
            'b0110: m_b = inp;
            'b1001: m_o = m_b;
            'b1101: m_o = im;
            'b1111: npc = im;
            'b0111: if (m_c == 0) npc = im;
            default: ;
        endcase
        m_pc = npc;
        m_c  = nc;
    endtask

    task automatic step(input logic e, input logic [3:0] op, input logic [3:0] im,
                        input logic [3:0] inp);
        state_t s;
        @(negedge clk);
        #1;
        en = e; opcode = op; immediate = im; in_port = inp;
        if (e) model_exec(int'(op), int'(im), int'(inp));
        s = '{pc: 4'(m_pc), a: 4'(m_a), b: 4'(m_b), o: 4'(m_o), c: (m_c != 0)};
        exp_q.push_back(s);
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    task automatic step8(input logic [3:0] op, input logic [7:0] im);
        @(negedge clk);
        #1;
        en8 = 1'b1; opcode8 = op; imm8 = im;
        @(posedge clk);
        #1;
        en8 = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk({name, "_pc"}, int'(pc_out), 0);
        chk({name, "_a"}, int'(reg_a), 0);
        chk({name, "_b"}, int'(reg_b), 0);
        chk({name, "_out"}, int'(out_port), 0);
        chk({name, "_carry"}, int'(carry), 0);
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0; failures = 0;
        en = 1'b0; opcode = '0; immediate = '0; in_port = '0;
        en8 = 1'b0; opcode8 = '0; imm8 = '0; in8 = '0;
        rst_n = 1'b1;
        model_reset();
        #1;
        do_reset("rst_init");

        // Add with carry, then NOP clears carry.
        step(1, 4'b1100, 4'h9, 4'h0);
        step(1, 4'b0000, 4'h8, 4'h0);
        chk("add_a", int'(reg_a), 1);
        chk("add_carry", int'(carry), 1);
        step(1, 4'b0001, 4'h0, 4'h0);
        chk("nop_carry", int'(carry), 0);
        chk("nop_pc", int'(pc_out), 3);

        // JNC not taken after carry, then taken.
        step(1, 4'b1100, 4'h1, 4'h0);
        step(1, 4'b0000, 4'hF, 4'h0);
        step(1, 4'b0111, 4'h0, 4'h0);
        chk("jnc_not_taken", int'(pc_out), 6);
        step(1, 4'b0111, 4'h0, 4'h0);
        chk("jnc_taken", int'(pc_out), 0);

        // I/O and moves.
        step(1, 4'b0110, 4'h0, 4'h5);
        step(1, 4'b1000, 4'h0, 4'h0);
        step(1, 4'b1001, 4'h0, 4'h0);
        chk("mov_ab", int'(reg_a), 5);
        chk("out_b", int'(out_port), 5);
        step(1, 4'b1101, 4'hA, 4'h0);
        chk("out_im", int'(out_port), 'hA);

        // PC wrap and hold.
        do_reset("rst_wrap");
        for (int i = 0; i < 15; i++) step(1, 4'b0011, 4'(i), 4'h0);
        chk("pc_15", int'(pc_out), 15);
        step(1, 4'b0101, 4'h0, 4'h0);
        chk("pc_wrap", int'(pc_out), 0);
        step(1, 4'b1110, 4'h7, 4'h0);
        for (int i = 0; i < 3; i++) step(0, 4'b1111, 4'h9, 4'h3);
        chk("hold_pc", int'(pc_out), 1);
        chk("hold_b", int'(reg_b), 7);

        // Randomised program.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        do_reset("rst_mid");
        for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 7) != 0), 4'($urandom), 4'($urandom), 4'($urandom));
        end

        // Wide instance: DW=8, AW=6.
        step8(4'b1100, 8'h01);
        step8(4'b0000, 8'hFF);
        chk("w8_add_a", int'(a8), 0);
        chk("w8_add_carry", int'(carry8), 1);
        step8(4'b1111, 8'h3F);
        chk("w8_jmp", int'(pc8), 63);
        step8(4'b0001, 8'h00);
        chk("w8_wrap", int'(pc8), 0);
        step8(4'b1111, 8'hC5);
        chk("w8_jmp_trunc", int'(pc8), 'h05);

        @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
